// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_pipe_param core: opcodes, controller states,
// forwarding selects and the control halves of the pipeline registers.
// The data halves depend on XLEN, so they live in the core itself.
package cpu_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_CMP   = 6'b000001;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;
  localparam logic [5:0] OP_JUMP  = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} ctrl_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } ifid_t;

  // Register indices are stored already reduced modulo NREG.
  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        wen;
    logic [15:0] imm;
    logic [25:0] jofs;
  } idex_ctl_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] op;
    logic [4:0] dest;
    logic       wen;
  } stage_ctl_t;

  // Result is known at the end of EX (forwardable from EX/MEM).
  function automatic logic writes_alu(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_CMP);
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    return writes_alu(op) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/cpu_hazard_unit.sv
// Hazard unit: EX operand forwarding selects, load-use stall and
// branch/jump flush. Purely combinational.
// Ports: ID/EX/MEM/WB stage control fields in; fwd_a_o/fwd_b_o, stall_o,
// flush_o out.
module cpu_hazard_unit
  import cpu_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_valid_i,
  input  logic [5:0] ex_op_i,
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] ex_dest_i,
  input  logic       ex_wen_i,
  input  logic       ex_eq_i,
  input  logic       mem_valid_i,
  input  logic [5:0] mem_op_i,
  input  logic [4:0] mem_dest_i,
  input  logic       mem_wen_i,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_dest_i,
  input  logic       wb_wen_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       stall_o,
  output logic       flush_o
);

  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // A LOAD sitting in EX/MEM has no data yet; the load-use stall covers it.
  // wen is never set for R0, so no separate R0 check is needed.
  assign mem_fwd_ok = mem_valid_i && mem_wen_i && writes_alu(mem_op_i);
  assign wb_fwd_ok  = wb_valid_i && wb_wen_i;

  always_comb begin
    fwd_a_o = FWD_RF;
    if (mem_fwd_ok && mem_dest_i == ex_rs_i)     fwd_a_o = FWD_MEM;
    else if (wb_fwd_ok && wb_dest_i == ex_rs_i)  fwd_a_o = FWD_WB;
    fwd_b_o = FWD_RF;
    if (mem_fwd_ok && mem_dest_i == ex_rt_i)     fwd_b_o = FWD_MEM;
    else if (wb_fwd_ok && wb_dest_i == ex_rt_i)  fwd_b_o = FWD_WB;
  end

  assign stall_o = ex_valid_i && ex_op_i == OP_LOAD && ex_wen_i && id_valid_i &&
                   (ex_dest_i == id_rs_i || ex_dest_i == id_rt_i);

  assign flush_o = ex_valid_i && (ex_op_i == OP_JUMP || (ex_op_i == OP_BEQ && ex_eq_i));

endmodule

// File: rtl/cpu_pipe_param.sv
// Parametrised five-stage pipelined core with run/halt controller and a
// program/data load port.
// Ports: clk, reset (async, active-low), run (start pulse), prog_we/prog_sel/
// prog_addr/prog_wdata (load port, idle/halted only), busy, halted,
// pc_out (IF word PC), retire_count.
// Controller:
//   state  | meaning
//   IDLE   | after reset, waiting for run
//   RUN    | pipeline executing
//   HALTED | HALT retired, state kept, waiting for run
module cpu_pipe_param
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  localparam int PW        = (XLEN > 32) ? XLEN : 32,
  localparam int IAW       = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            prog_we,
  input  logic            prog_sel,
  input  logic [15:0]     prog_addr,
  input  logic [PW-1:0]   prog_wdata,
  output logic            busy,
  output logic            halted,
  output logic [IAW-1:0]  pc_out,
  output logic [31:0]     retire_count
);

  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int RW  = $clog2(NREG);
  localparam logic [4:0] RMASK = 5'(NREG - 1);

  ctrl_state_e      state_q;
  logic             busy_q, halted_q, halt_seen_q;
  logic [IAW-1:0]   pc_q, ifid_pc_q, idex_pc_q;
  logic [31:0]      retire_q;
  ifid_t            ifid_q;
  idex_ctl_t        idex_q;
  stage_ctl_t       exmem_q, memwb_q;
  logic [XLEN-1:0]  idex_a_q, idex_b_q, exmem_res_q, exmem_sdata_q, memwb_res_q;
  logic [DAW-1:0]   exmem_didx_q;
  logic [XLEN-1:0]  dmem_rdata_q;

  logic [XLEN-1:0]  rf   [NREG];
  logic [31:0]      imem [IMEM_DEPTH];
  logic [XLEN-1:0]  dmem [DMEM_DEPTH];

  logic [5:0]       id_op;
  logic [4:0]       id_rs, id_rt, id_rd, id_dest;
  logic             id_wen, wb_we, fetch_block;
  logic [XLEN-1:0]  id_a, id_b, wb_val, op_a, op_b, ex_sum, ex_addr, ex_res;
  logic             ex_eq, ex_lt;
  logic [31:0]      ex_tgt32;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall, flush;

  // ---------------- ID ----------------
  assign id_op   = ifid_q.instr[31:26];
  assign id_rs   = ifid_q.instr[25:21] & RMASK;
  assign id_rt   = ifid_q.instr[20:16] & RMASK;
  assign id_rd   = ifid_q.instr[15:11] & RMASK;
  assign id_dest = (id_op == OP_LOAD) ? id_rt : id_rd;
  assign id_wen  = writes_reg(id_op) && id_dest != 5'd0;

  assign wb_val = (memwb_q.op == OP_LOAD) ? dmem_rdata_q : memwb_res_q;
  assign wb_we  = state_q == RUN && memwb_q.valid && memwb_q.wen;

  // Write-first: the value retiring this cycle is what ID sees.
  always_comb begin
    id_a = rf[id_rs[RW-1:0]];
    id_b = rf[id_rt[RW-1:0]];
    if (wb_we && memwb_q.dest == id_rs) id_a = wb_val;
    if (wb_we && memwb_q.dest == id_rt) id_b = wb_val;
  end

  // Once HALT is decoded nothing younger may enter the pipe.
  assign fetch_block = halt_seen_q || (ifid_q.valid && id_op == OP_HALT);

  // ---------------- EX ----------------
  always_comb begin
    case (fwd_a)
      FWD_MEM: op_a = exmem_res_q;
      FWD_WB:  op_a = wb_val;
      default: op_a = idex_a_q;
    endcase
    case (fwd_b)
      FWD_MEM: op_b = exmem_res_q;
      FWD_WB:  op_b = wb_val;
      default: op_b = idex_b_q;
    endcase
  end

  assign ex_sum   = op_a + op_b;
  assign ex_addr  = op_a + XLEN'($signed(idex_q.imm));
  assign ex_lt    = $signed(op_a) < $signed(op_b);
  assign ex_eq    = op_a == op_b;
  assign ex_res   = (idex_q.op == OP_CMP) ? XLEN'(ex_lt) : ex_sum;
  // Low IAW bits of the sign-extended sum give PC wrap modulo IMEM_DEPTH.
  assign ex_tgt32 = 32'(idex_pc_q) + ((idex_q.op == OP_JUMP) ? 32'($signed(idex_q.jofs))
                                                              : 32'($signed(idex_q.imm)));

  cpu_hazard_unit u_hazard (
    .id_valid_i  (ifid_q.valid),
    .id_rs_i     (id_rs),
    .id_rt_i     (id_rt),
    .ex_valid_i  (idex_q.valid),
    .ex_op_i     (idex_q.op),
    .ex_rs_i     (idex_q.rs),
    .ex_rt_i     (idex_q.rt),
    .ex_dest_i   (idex_q.dest),
    .ex_wen_i    (idex_q.wen),
    .ex_eq_i     (ex_eq),
    .mem_valid_i (exmem_q.valid),
    .mem_op_i    (exmem_q.op),
    .mem_dest_i  (exmem_q.dest),
    .mem_wen_i   (exmem_q.wen),
    .wb_valid_i  (memwb_q.valid),
    .wb_dest_i   (memwb_q.dest),
    .wb_wen_i    (memwb_q.wen),
    .fwd_a_o     (fwd_a),
    .fwd_b_o     (fwd_b),
    .stall_o     (stall),
    .flush_o     (flush)
  );

  // ---------------- controller + pipeline registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      halt_seen_q   <= 1'b0;
      pc_q          <= '0;
      retire_q      <= '0;
      ifid_q        <= '0;
      ifid_pc_q     <= '0;
      idex_q        <= '0;
      idex_pc_q     <= '0;
      idex_a_q      <= '0;
      idex_b_q      <= '0;
      exmem_q       <= '0;
      exmem_res_q   <= '0;
      exmem_sdata_q <= '0;
      exmem_didx_q  <= '0;
      memwb_q       <= '0;
      memwb_res_q   <= '0;
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (run) begin
            state_q       <= RUN;
            busy_q        <= 1'b1;
            halted_q      <= 1'b0;
            halt_seen_q   <= 1'b0;
            pc_q          <= '0;
            retire_q      <= '0;
            ifid_q.valid  <= 1'b0;
            idex_q.valid  <= 1'b0;
            exmem_q.valid <= 1'b0;
            memwb_q.valid <= 1'b0;
          end
        end
        RUN: begin
          memwb_q       <= exmem_q;
          memwb_res_q   <= exmem_res_q;
          exmem_q       <= '{valid: idex_q.valid, op: idex_q.op, dest: idex_q.dest, wen: idex_q.wen};
          exmem_res_q   <= ex_res;
          exmem_sdata_q <= op_b;
          exmem_didx_q  <= ex_addr[DAW+1:2];

          if (flush || stall) begin
            idex_q.valid <= 1'b0;
          end else begin
            idex_q    <= '{valid: ifid_q.valid, op: id_op, rs: id_rs, rt: id_rt, dest: id_dest,
                           wen: id_wen, imm: ifid_q.instr[15:0], jofs: ifid_q.instr[25:0]};
            idex_pc_q <= ifid_pc_q;
            idex_a_q  <= id_a;
            idex_b_q  <= id_b;
          end

          if (flush) begin
            ifid_q.valid <= 1'b0;
            pc_q         <= ex_tgt32[IAW-1:0];
          end else if (!stall) begin
            if (fetch_block) begin
              ifid_q.valid <= 1'b0;
            end else begin
              ifid_q    <= '{valid: 1'b1, instr: imem[pc_q]};
              ifid_pc_q <= pc_q;
              pc_q      <= pc_q + IAW'(1);
            end
            if (ifid_q.valid && id_op == OP_HALT) halt_seen_q <= 1'b1;
          end

          if (memwb_q.valid) retire_q <= retire_q + 32'd1;

          if (memwb_q.valid && memwb_q.op == OP_HALT) begin
            state_q       <= HALTED;
            busy_q        <= 1'b0;
            halted_q      <= 1'b1;
            ifid_q.valid  <= 1'b0;
            idex_q.valid  <= 1'b0;
            exmem_q.valid <= 1'b0;
            memwb_q.valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb_q.dest[RW-1:0]] <= wb_val;
    end
  end

  // Memories are not reset. Stage valids clear asynchronously, so no store
  // can land once reset is asserted.
  always_ff @(posedge clk) begin
    if (prog_we && state_q != RUN) begin
      if (!prog_sel) imem[prog_addr[IAW-1:0]] <= prog_wdata[31:0];
      else           dmem[prog_addr[DAW-1:0]] <= prog_wdata[XLEN-1:0];
    end
    if (state_q == RUN && exmem_q.valid && exmem_q.op == OP_STORE)
      dmem[exmem_didx_q] <= exmem_sdata_q;
    dmem_rdata_q <= dmem[exmem_didx_q];
  end

  assign busy         = busy_q;
  assign halted       = halted_q;
  assign pc_out       = pc_q;
  assign retire_count = retire_q;

  logic unused_bits;
  assign unused_bits = ^{prog_addr, prog_wdata, ex_addr, ex_tgt32};

endmodule

// File: tb/tb_cpu_pipe_param.sv
module tb_cpu_pipe_param;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run, run16, prog_we, prog_sel;
  logic [15:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        busy, halted, busy16, halted16;
  logic [7:0]  pc_out, pc_out16;
  logic [31:0] retire_count, retire16;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic [31:0] pg[$];

  always #5 clk = ~clk;

  cpu_pipe_param dut (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy), .halted(halted),
    .pc_out(pc_out), .retire_count(retire_count)
  );

  cpu_pipe_param #(.XLEN(16)) dut16 (
    .clk(clk), .reset(reset), .run(run16), .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .busy(busy16), .halted(halted16),
    .pc_out(pc_out16), .retire_count(retire16)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic pwrite(input logic sel, input int addr, input logic [31:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_sel = sel; prog_addr = 16'(addr); prog_wdata = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_pg();
    foreach (pg[i]) pwrite(1'b0, i, pg[i]);
  endtask

  // c = edges after the run-sampling edge until halted is seen high
  task automatic run_wait(input bit w16, output int c);
    @(negedge clk);
    if (w16) run16 = 1'b1; else run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0; run16 = 1'b0;
    c = 0;
    while (!(w16 ? halted16 : halted) && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; run16 = 1'b0;
    prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0; prog_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    reset = 1'b1;

    pwrite(1'b1, 1, 32'd100);
    pwrite(1'b1, 16, 32'd10);
    pwrite(1'b1, 17, 32'd5);
    pwrite(1'b1, 20, 32'h0000_FFFF);
    pwrite(1'b1, 21, 32'd1);

    // base program, R1/R2 prologue via loads
    pg = '{itype(OP_LOAD, 0, 1, 64), itype(OP_LOAD, 0, 2, 68),
           rtype(OP_ADD, 1, 2, 3), rtype(OP_CMP, 1, 2, 4),
           itype(OP_LOAD, 5, 6, 4), itype(OP_STORE, 5, 6, 8),
           {OP_JUMP, 26'd2}, rtype(OP_ADD, 1, 1, 7), {OP_HALT, 26'd0}};
    load_pg();
    run_wait(1'b0, cyc);
    chk("base_halted", 32'(halted), 32'd1);
    chk("base_busy", 32'(busy), 32'd0);
    chk("base_r3", dut.rf[3], 32'd15);
    chk("base_r4", dut.rf[4], 32'd0);
    chk("base_r6", dut.rf[6], 32'd100);
    chk("base_dmem2", dut.dmem[2], 32'd100);
    chk("base_r7", dut.rf[7], 32'd0);
    chk("base_retire", retire_count, 32'd8);

    // back-to-back forwarding, restart from HALTED
    pg = '{rtype(OP_ADD, 1, 2, 3), rtype(OP_ADD, 3, 3, 4),
           rtype(OP_ADD, 4, 3, 5), {OP_HALT, 26'd0}};
    load_pg();
    run_wait(1'b0, cyc);
    chk("b2b_r4", dut.rf[4], 32'd30);
    chk("b2b_r5", dut.rf[5], 32'd45);
    chk("b2b_cycles", 32'(cyc), 32'd8);
    chk("b2b_retire", retire_count, 32'd4);

    // load-use: one stall cycle
    pg = '{itype(OP_LOAD, 0, 6, 4), rtype(OP_ADD, 6, 1, 7), {OP_HALT, 26'd0}};
    load_pg();
    run_wait(1'b0, cyc);
    chk("lu_r7", dut.rf[7], 32'd110);
    chk("lu_cycles", 32'(cyc), 32'd8);
    chk("lu_retire", retire_count, 32'd3);

    // taken BEQ skips two ADDs, two-cycle penalty
    pg = '{itype(OP_BEQ, 1, 1, 3), rtype(OP_ADD, 1, 1, 8),
           rtype(OP_ADD, 1, 1, 8), {OP_HALT, 26'd0}};
    load_pg();
    run_wait(1'b0, cyc);
    chk("beqt_r8", dut.rf[8], 32'd0);
    chk("beqt_cycles", 32'(cyc), 32'd8);
    chk("beqt_retire", retire_count, 32'd2);

    // not-taken BEQ, no penalty
    pg = '{itype(OP_BEQ, 1, 2, 3), rtype(OP_ADD, 1, 2, 8), {OP_HALT, 26'd0}};
    load_pg();
    run_wait(1'b0, cyc);
    chk("beqn_r8", dut.rf[8], 32'd15);
    chk("beqn_cycles", 32'(cyc), 32'd7);
    chk("beqn_retire", retire_count, 32'd3);

    // XLEN=16 wrap and signed compare
    pg = '{itype(OP_LOAD, 0, 1, 80), itype(OP_LOAD, 0, 2, 84),
           rtype(OP_ADD, 1, 2, 3), rtype(OP_CMP, 1, 2, 4), {OP_HALT, 26'd0}};
    load_pg();
    run_wait(1'b1, cyc);
    chk("x16_halted", 32'(halted16), 32'd1);
    chk("x16_add", 32'(dut16.rf[3]), 32'd0);
    chk("x16_cmp", 32'(dut16.rf[4]), 32'd1);

    // reset mid-loop
    pg = '{{OP_JUMP, 26'd0}};
    load_pg();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (20) @(negedge clk);
    chk("loop_busy", 32'(busy), 32'd1);
    pwrite(1'b1, 1, 32'd555);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_halted", 32'(halted), 32'd0);
    chk("mrst_pc", 32'(pc_out), 32'd0);
    chk("mrst_retire", retire_count, 32'd0);
    chk("mrst_rf6", dut.rf[6], 32'd0);
    chk("mrst_dmem1", dut.dmem[1], 32'd100);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    chk("rerun_busy", 32'(busy), 32'd1);
    chk("rerun_pc0", 32'(pc_out), 32'd0);
    chk("rerun_retire", retire_count, 32'd0);
    @(posedge clk); #1;
    chk("rerun_pc1", 32'(pc_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
